alu_result_select_pipe: RTL and testbench



---
 rtl/alu_pkg.sv | 20 ++
 rtl/skid_buffer.sv | 64 ++++++
 rtl/alu_result_select_pipe.sv | 61 ++++++
 tb/tb_alu_result_select_pipe.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU logic-result selection path: slot indices,
// select-width derivation and the registered payload layout.
package alu_pkg;

   localparam int unsigned OP_AND = 0;
   localparam int unsigned OP_OR  = 1;
   localparam int unsigned OP_XOR = 2;
   localparam int unsigned OP_NOR = 3;

   // A single-input-pair selector still needs one select bit.
   function automatic int unsigned sel_width(input int unsigned num_in);
      return (num_in <= 2) ? 1 : $clog2(num_in);
   endfunction

   // Payload packed MSB->LSB as {data, zero, err, sel}.
   function automatic int unsigned pay_width(input int unsigned width, input int unsigned sel_w);
      return width + 2 + sel_w;
   endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer: main register M drives the outputs and
// skid register S absorbs one beat so in_ready never depends on out_ready.
module skid_buffer #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] in_pay,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_pay,
   output logic         out_valid,
   input  logic         out_ready
);

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t       st;
   logic [W-1:0] m_pay;
   logic [W-1:0] s_pay;
   logic         acc;
   logic         drn;

   assign out_valid = (st != EMPTY);
   assign out_pay   = m_pay;
   assign in_ready  = rst_n & (st != FULL);
   assign acc       = in_valid & in_ready;
   assign drn       = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st    <= EMPTY;
         m_pay <= '0;
         s_pay <= '0;
      end else begin
         case (st)
            EMPTY: begin
               if (acc) begin
                  m_pay <= in_pay;
                  st    <= ONE;
               end
            end
            ONE: begin
               if (acc && drn) begin
                  m_pay <= in_pay;
               end else if (acc) begin
                  s_pay <= in_pay;
                  st    <= FULL;
               end else if (drn) begin
                  st <= EMPTY;
               end
            end
            FULL: begin
               if (drn) begin
                  m_pay <= s_pay;
                  st    <= ONE;
               end
            end
            default: st <= EMPTY;
         endcase
      end
   end

endmodule

// File: rtl/alu_result_select_pipe.sv
// Pipelined ALU logic-result selector: picks one of NUM_IN candidates, flags
// zero/out-of-range, and registers the beat behind a skid buffer.
module alu_result_select_pipe
   import alu_pkg::*;
#(
   parameter  int unsigned WIDTH  = 32,
   parameter  int unsigned NUM_IN = 4,
   localparam int unsigned SEL_W  = sel_width(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_zero,
   output logic                    out_err,
   output logic [SEL_W-1:0]        out_sel,
   output logic                    out_valid,
   input  logic                    out_ready
);

   localparam int unsigned PW = pay_width(WIDTH, SEL_W);

   logic [WIDTH-1:0] sel_data;
   logic             sel_err;
   logic [PW-1:0]    in_pay;
   logic [PW-1:0]    out_pay;

   // err starts set and is cleared only by a matching slot, so unmatched
   // select codes (NUM_IN not a power of two) yield data 0 with err=1.
   always_comb begin
      sel_data = '0;
      sel_err  = 1'b1;
      for (int unsigned k = 0; k < NUM_IN; k++) begin
         if (in_sel == SEL_W'(k)) begin
            sel_data = in_data[k*WIDTH +: WIDTH];
            sel_err  = 1'b0;
         end
      end
   end

   assign in_pay = {sel_data, ~|sel_data, sel_err, in_sel};

   skid_buffer #(
      .W(PW)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_pay    (in_pay),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_pay   (out_pay),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   assign {out_data, out_zero, out_err, out_sel} = out_pay;

endmodule

// File: tb/tb_alu_result_select_pipe.sv
// Self-checking bench: vector tables, hand-written handshake/reset sequences
// and a randomized stream against a queue-based reference model.
module tb_alu_result_select_pipe;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // default instance: WIDTH=32, NUM_IN=4
   logic [127:0] in_data;
   logic [1:0]   in_sel;
   logic         in_valid, in_ready, out_valid, out_ready, out_zero, out_err;
   logic [31:0]  out_data;
   logic [1:0]   out_sel;

   // non-power-of-two instance: WIDTH=16, NUM_IN=5
   logic [79:0]  b_in_data;
   logic [2:0]   b_in_sel;
   logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_zero, b_out_err;
   logic [15:0]  b_out_data;
   logic [2:0]   b_out_sel;

   alu_result_select_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
      .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
      .out_zero(out_zero), .out_err(out_err), .out_sel(out_sel),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   alu_result_select_pipe #(.WIDTH(16), .NUM_IN(5)) dut5 (
      .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_sel(b_in_sel),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
      .out_zero(b_out_zero), .out_err(b_out_err), .out_sel(b_out_sel),
      .out_valid(b_out_valid), .out_ready(b_out_ready)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [35:0] exp_a(input logic [127:0] d, input logic [1:0] s);
      logic [31:0] v;
      v = d[s*32 +: 32];
      return {v, v == 32'd0, 1'b0, s};
   endfunction

   function automatic logic [20:0] exp_b(input logic [79:0] d, input logic [2:0] s);
      logic [15:0] v;
      v = (s < 5) ? d[s*16 +: 16] : 16'd0;
      return {v, v == 16'd0, s >= 5, s};
   endfunction

   typedef struct {
      logic [1:0]   sel;
      logic [127:0] slots;
      logic [31:0]  d;
      logic         z;
   } vec_a_t;

   typedef struct {
      logic [2:0]  sel;
      logic [79:0] slots;
      logic [15:0] d;
      logic        z;
      logic        e;
   } vec_b_t;

   vec_a_t va[6];
   vec_b_t vb[6];
   logic [35:0] qa[$];
   logic [20:0] qb[$];
   logic [127:0] p1, p2;
   logic [79:0]  pb;

   initial begin
      p1 = {32'h0000_0000, 32'hF0F0_0F0F, 32'hFFFF_0000, 32'h0000_00FF};
      p2 = {32'h1234_5678, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0001};
      pb = {16'hA5A5, 16'h0000, 16'h00FF, 16'h8000, 16'h7FFF};
      va[0] = '{2'(OP_XOR), p1, 32'hF0F0_0F0F, 1'b0};
      va[1] = '{2'(OP_NOR), p1, 32'h0000_0000, 1'b1};
      va[2] = '{2'(OP_AND), p1, 32'h0000_00FF, 1'b0};
      va[3] = '{2'(OP_OR),  p1, 32'hFFFF_0000, 1'b0};
      va[4] = '{2'(OP_XOR), p2, 32'h0000_0000, 1'b1};
      va[5] = '{2'(OP_NOR), p2, 32'h1234_5678, 1'b0};
      vb[0] = '{3'd6, pb, 16'h0000, 1'b1, 1'b1};
      vb[1] = '{3'd4, pb, 16'hA5A5, 1'b0, 1'b0};
      vb[2] = '{3'd5, pb, 16'h0000, 1'b1, 1'b1};
      vb[3] = '{3'd7, pb, 16'h0000, 1'b1, 1'b1};
      vb[4] = '{3'd3, pb, 16'h0000, 1'b1, 1'b0};
      vb[5] = '{3'd0, pb, 16'h7FFF, 1'b0, 1'b0};

      rst_n = 1'b0;
      in_data = '0; in_sel = '0; in_valid = 1'b0; out_ready = 1'b1;
      b_in_data = '0; b_in_sel = '0; b_in_valid = 1'b0; b_out_ready = 1'b1;

      // reset then idle
      for (int i = 0; i < 2; i++) begin
         step();
         check("rst_in_ready", in_ready, 1'b0);
         check("rst_out_valid", out_valid, 1'b0);
         check("rst_out_data", out_data, 32'd0);
         check("rst_b_in_ready", b_in_ready, 1'b0);
      end
      rst_n = 1'b1;
      #1;
      check("post_rst_in_ready", in_ready, 1'b1);
      step();
      check("idle_out_valid", out_valid, 1'b0);
      check("idle_in_ready", in_ready, 1'b1);

      // table vectors, streaming with out_ready=1
      foreach (va[i]) begin
         in_data = va[i].slots; in_sel = va[i].sel; in_valid = 1'b1;
         step();
         check("tab_a_valid", out_valid, 1'b1);
         check("tab_a_data", out_data, va[i].d);
         check("tab_a_zero", out_zero, va[i].z);
         check("tab_a_err", out_err, 1'b0);
         check("tab_a_sel", out_sel, va[i].sel);
      end
      in_valid = 1'b0;
      step();
      check("tab_a_drained", out_valid, 1'b0);

      foreach (vb[i]) begin
         b_in_data = vb[i].slots; b_in_sel = vb[i].sel; b_in_valid = 1'b1;
         step();
         check("tab_b_valid", b_out_valid, 1'b1);
         check("tab_b_data", b_out_data, vb[i].d);
         check("tab_b_zero", b_out_zero, vb[i].z);
         check("tab_b_err", b_out_err, vb[i].e);
         check("tab_b_sel", b_out_sel, vb[i].sel);
      end
      b_in_valid = 1'b0;
      step();
      check("tab_b_drained", b_out_valid, 1'b0);

      // back-pressure: A then B with out_ready=0
      out_ready = 1'b0;
      in_data = p1; in_sel = 2'(OP_AND); in_valid = 1'b1;
      step();
      check("bp_ready_after_a", in_ready, 1'b1);
      in_sel = 2'(OP_OR);
      step();
      check("bp_ready_after_b", in_ready, 1'b0);
      check("bp_hold_a", out_data, 32'h0000_00FF);
      in_sel = 2'(OP_XOR);
      step();
      check("bp_stable_a", {out_valid, out_data, out_sel}, {1'b1, 32'h0000_00FF, 2'd0});
      check("bp_still_full", in_ready, 1'b0);
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      check("bp_b_out", {out_valid, out_data, out_sel}, {1'b1, 32'hFFFF_0000, 2'd1});
      check("bp_ready_back", in_ready, 1'b1);
      step();
      check("bp_empty", out_valid, 1'b0);

      // reset while FULL
      out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'(OP_XOR);
      step();
      step();
      check("mid_full", in_ready, 1'b0);
      in_valid = 1'b0; rst_n = 1'b0;
      step();
      check("mid_rst_valid", out_valid, 1'b0);
      check("mid_rst_ready", in_ready, 1'b0);
      rst_n = 1'b1; out_ready = 1'b1;
      #1;
      check("mid_rel_ready", in_ready, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         check("mid_no_stale", out_valid, 1'b0);
      end

      // randomized stream against queue model, last cycles drain
      for (int i = 0; i < 1006; i++) begin
         logic fin;
         fin = (i >= 1000);
         check("s_a_valid", out_valid, qa.size() != 0);
         check("s_a_ready", in_ready, qa.size() < 2);
         out_ready = fin ? 1'b1 : ($urandom_range(0, 3) != 0);
         if (out_valid && out_ready && qa.size() != 0)
            check("s_a_beat", {out_data, out_zero, out_err, out_sel}, qa.pop_front());
         for (int k = 0; k < 4; k++)
            in_data[k*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         in_sel = 2'($urandom);
         in_valid = fin ? 1'b0 : 1'($urandom_range(0, 1));
         if (in_valid && in_ready) qa.push_back(exp_a(in_data, in_sel));

         check("s_b_valid", b_out_valid, qb.size() != 0);
         check("s_b_ready", b_in_ready, qb.size() < 2);
         b_out_ready = fin ? 1'b1 : ($urandom_range(0, 2) != 0);
         if (b_out_valid && b_out_ready && qb.size() != 0)
            check("s_b_beat", {b_out_data, b_out_zero, b_out_err, b_out_sel}, qb.pop_front());
         for (int k = 0; k < 5; k++)
            b_in_data[k*16 +: 16] = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
         b_in_sel = 3'($urandom);
         b_in_valid = fin ? 1'b0 : 1'($urandom_range(0, 1));
         if (b_in_valid && b_in_ready) qb.push_back(exp_b(b_in_data, b_in_sel));
         step();
      end
      check("s_a_left", qa.size(), 0);
      check("s_b_left", qb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
